spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Single-channel SPI master that sequences 24-bit command frames {opcode, addr, data} to the board's SPI slave (spi/spi2 register interface) from a valid/ready request port. Generates sclk/csn/mosi (mode 0, MSB first) from the system clock via an integer divider, captures miso, and returns the final received byte on a response pulse. Replaces bench-driven stimulus in hardware and is the sole owner of the SPI pins.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period (sclk = clk/(2*CLK_DIV)); legal >=1
CS_SETUP, 5, clk cycles csn low before first sclk rise; legal >=1
CS_HOLD, 5, clk cycles after last sclk fall before csn high; legal >=1
CS_GAP, 4, minimum clk cycles csn high between frames; legal >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted when valid&ready
req_opcode  in  8  frame byte 0
req_addr  in  8  frame byte 1
req_wdata  in  8  frame byte 2
rsp_valid  out  1  one-cycle pulse, frame complete
rsp_rdata  out  8  last 8 miso bits of frame, valid with rsp_valid
busy  out  1  high from acceptance until return to IDLE
sclk_o  out  1  SPI clock, idle low
csn_o  out  1  chip select, active low
mosi_o  out  1  master data out
miso_i  in  1  slave data in (synchronous to sclk_o; no synchroniser, captured on internal rise strobe)

Behaviour:
- Reset (sync): state IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, sclk_o=0, csn_o=1, mosi_o=0. All outputs registered.
- Handshake: req_ready = (state==IDLE). On valid&ready capture 24-bit shift reg {opcode,addr,wdata}; req fields ignored thereafter. req_valid while busy ignored, no queueing.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP: entered cycle after acceptance; csn_o=0, mosi_o=bit23, sclk_o=0; lasts CS_SETUP cycles.
- SHIFT: 24 bits; each bit = CLK_DIV cycles sclk_o=0 then CLK_DIV cycles sclk_o=1. Rise strobe: miso_i shifted into rx reg (LSB in). Fall strobe: mosi_o advances to next bit; after 24th fall go HOLD (mosi_o=0).
- HOLD: csn_o=0, sclk_o=0, CS_HOLD cycles.
- GAP entry: csn_o=1; rsp_valid=1 for exactly that cycle, rsp_rdata=rx[7:0] (held until next response). Stay CS_GAP cycles, then IDLE.
- Frame timing: csn_o low exactly CS_SETUP+48*CLK_DIV+CS_HOLD cycles; exactly 24 sclk rises per frame; acceptance to rsp_valid = 1+that count; acceptance to next req_ready = 1+that count+CS_GAP.
- busy = !(state==IDLE).
- Reset mid-frame: next cycle outputs at reset values, no rsp_valid, partial frame abandoned.
- Counters: half-period counter width $clog2(CLK_DIV+1), bit counter 5 bits (0..23), setup/hold/gap counter sized to max of those params.
- Elaboration assertion fails if any parameter < 1.

Decomposition:
- Package spi_pkg: state enum typedef (IDLE, SETUP, SHIFT, HOLD, GAP), FRAME_BITS=24, opcode constant SPI_OP_RD=8'h40.
- Sub-module spi_sclk_gen: parameterised by CLK_DIV, enable input, outputs sclk level plus one-cycle rise/fall strobes; counter resets when disabled so first rise always CLK_DIV cycles after enable.

Test Plan:
- CLK_DIV=2, req {0x40,0x01,0x00}, slave td0=0x80 -> mosi bit stream 0x400100 sampled on sclk rises, 24 rises, csn low 106 cycles, rsp_rdata=0x80.
- Repeat with td0=0x03 then td0=0xC0 back-to-back (req_valid held high) -> rsp_rdata 0x03, 0xC0; csn high >=4 cycles between frames; req_ready low throughout each frame.
- req_valid pulsed during SHIFT with different fields -> ignored; frame bits unchanged, only one rsp_valid.
- rst asserted at 10th sclk rise -> next cycle csn_o=1, sclk_o=0, mosi_o=0, req_ready=1, no rsp_valid; following request completes normally.
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1 -> sclk = clk/2, csn low 50 cycles, rsp_valid exactly 51 cycles after acceptance.
- miso held 1 for entire frame -> rsp_rdata=0xFF; miso toggling 1/0 per bit starting 1 -> rsp_rdata=0xAA.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
//   spi_state_e : controller FSM states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   FRAME_BITS  : bits per command frame {opcode, addr, data}
//   SPI_OP_RD   : register-read opcode understood by the board's SPI slave
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int FRAME_BITS = 24;
  localparam logic [7:0] SPI_OP_RD = 8'h40;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator.
// Produces a registered sclk level that toggles every CLK_DIV cycles while
// enabled, plus one-cycle strobes flagging that sclk rises (rise_o) or falls
// (fall_o) at the next clock edge. While disabled the counter and sclk are
// held at zero, so the first rise is always 2*CLK_DIV cycles... no: the first
// rise always lands CLK_DIV cycles after enable is raised.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en_i     : run the divider
//   sclk_o   : SPI clock level (idle low)
//   rise_o   : sclk goes high at the next edge
//   fall_o   : sclk goes low at the next edge
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int HC_W = $clog2(CLK_DIV + 1);

  logic [HC_W-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            wrap;

  assign wrap   = en_i && (cnt_q == HC_W'(CLK_DIV - 1));
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-channel SPI master (mode 0, MSB first) sequencing 24-bit frames
// {opcode, addr, wdata} and returning the last 8 received miso bits.
// Handshake: a request is taken on any clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and request
// fields are not looked at again until the controller returns to IDLE.
// Ports:
//   clk, rst                          : system clock, sync active-high reset
//   req_valid/req_ready               : request handshake
//   req_opcode/req_addr/req_wdata     : frame bytes 0..2
//   rsp_valid/rsp_rdata               : one-cycle completion pulse + data
//   busy                              : frame in progress (state != IDLE)
//   sclk_o/csn_o/mosi_o/miso_i        : SPI pins
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 5,
  parameter int CS_HOLD  = 5,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_opcode,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk_o,
  output logic       csn_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1) begin : g_bad_param
    $error("spi_master_ctrl: CLK_DIV, CS_SETUP, CS_HOLD and CS_GAP must all be >= 1");
  end

  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                           ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  spi_state_e            state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [4:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [7:0]            rx_q, rx_d;
  logic                  csn_q, csn_d;
  logic                  mosi_q, mosi_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [7:0]            rsp_rdata_q, rsp_rdata_d;
  logic                  ready_q, busy_q;
  logic                  rise_stb, fall_stb;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == SHIFT),
    .sclk_o (sclk_o),
    .rise_o (rise_stb),
    .fall_o (fall_stb)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    csn_d       = csn_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          tx_d    = {req_opcode, req_addr, req_wdata};
          mosi_d  = req_opcode[7];
          csn_d   = 1'b0;
          tmr_d   = '0;
          bit_d   = '0;
          rx_d    = '0;
        end
      end
      SETUP: begin
        if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SHIFT: begin
        if (rise_stb) rx_d = {rx_q[6:0], miso_i};
        if (fall_stb) begin
          if (bit_q == 5'(FRAME_BITS - 1)) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            mosi_d = tx_q[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
          state_d     = GAP;
          tmr_d       = '0;
          csn_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == TMR_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      csn_q       <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      csn_q       <= csn_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      // Decoded from the next state so both stay pure register outputs.
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign csn_o     = csn_q;
  assign mosi_o    = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default timing and the minimum
// CLK_DIV=1 / 1-cycle csn timing), exercised one at a time through a shared
// monitor that plays the SPI slave and scores every response.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  // Reference timing, straight from the frame rules: csn low for
  // setup + 24 bits * 2 half-periods + hold cycles.
  localparam int LOW0 = 5 + 48 * 2 + 5;
  localparam int LOW1 = 1 + 48 * 1 + 1;
  localparam int GAP0 = 4;
  localparam int GAP1 = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rv, rr, busy_w, rsp_w, sclk_w, csn_w, mosi_w;
  logic [1:0][7:0]  rdata_w;
  logic [7:0]       opcode, addr, wdata;
  logic             miso;
  int               sel;
  int               cyc;

  int cmp_cnt;
  int err_cnt;

  // {accept cycle[31:0], frame bits[23:0], expected rdata[7:0]}
  logic [63:0] exp_q[$];
  logic [23:0] miso_q[$];

  int mon_rises;

  spi_master_ctrl #(.CLK_DIV(2), .CS_SETUP(5), .CS_HOLD(5), .CS_GAP(4)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_opcode(opcode), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rsp_w[0]), .rsp_rdata(rdata_w[0]), .busy(busy_w[0]),
    .sclk_o(sclk_w[0]), .csn_o(csn_w[0]), .mosi_o(mosi_w[0]), .miso_i(miso)
  );

  spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_opcode(opcode), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rsp_w[1]), .rsp_rdata(rdata_w[1]), .busy(busy_w[1]),
    .sclk_o(sclk_w[1]), .csn_o(csn_w[1]), .mosi_o(mosi_w[1]), .miso_i(miso)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (dut %0d, t=%0t)", name, act, req, sel, $time);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rv  = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Present a request; keep=1 leaves req_valid high for a back-to-back frame.
  task automatic send(input int s, input logic [7:0] op, input logic [7:0] ad,
                      input logic [7:0] wd, input logic [23:0] pat, input bit keep);
    int k;
    opcode = op;
    addr   = ad;
    wdata  = wd;
    rv[s]  = 1'b1;
    k = 0;
    while (!rr[s] && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!rr[s]) begin
      check("accept_timeout", 32'd0, 32'd1);
      rv[s] = 1'b0;
    end else begin
      // Acceptance happens on the coming edge: expected rdata is simply the
      // last byte the slave will shift out.
      exp_q.push_back({cyc[31:0], op, ad, wd, pat[7:0]});
      miso_q.push_back(pat);
      @(negedge clk);
      if (!keep) rv[s] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int s);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !rr[s]) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rises(input int n);
    int k;
    k = 0;
    while (mon_rises < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rise_wait_timeout", (mon_rises >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input int s);
    check("rst_req_ready", {31'd0, rr[s]}, 32'd1);
    check("rst_busy", {31'd0, busy_w[s]}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_w[s]}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rdata_w[s]}, 32'd0);
    check("rst_sclk", {31'd0, sclk_w[s]}, 32'd0);
    check("rst_csn", {31'd0, csn_w[s]}, 32'd1);
    check("rst_mosi", {31'd0, mosi_w[s]}, 32'd0);
  endtask

  // ---------------- monitor / slave / scoreboard ----------------
  initial begin
    logic        pc, ps, pr, c, s;
    logic [23:0] pat, mosi_cap;
    logic [63:0] e;
    int          bit_k, csn_low, low_len, gap_cnt, exp_low, exp_gap;
    bit          ready_viol;
    pc = 1'b1; ps = 1'b0; pr = 1'b0; pat = '0; mosi_cap = '0;
    bit_k = 0; csn_low = 0; low_len = 0; gap_cnt = 1000; ready_viol = 1'b0;
    mon_rises = 0;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      exp_low = (sel == 0) ? LOW0 : LOW1;
      exp_gap = (sel == 0) ? GAP0 : GAP1;
      if (rst) begin
        pc = 1'b1; ps = 1'b0; pr = 1'b0; miso = 1'b0;
        mon_rises = 0; csn_low = 0; gap_cnt = 1000;
      end else begin
        c = csn_w[sel];
        s = sclk_w[sel];
        if (pc && !c) begin
          check("csn_gap_min", (gap_cnt >= exp_gap) ? 32'd1 : 32'd0, 32'd1);
          pat        = (miso_q.size() != 0) ? miso_q.pop_front() : 24'd0;
          bit_k      = 0;
          miso       = pat[23];
          mon_rises  = 0;
          mosi_cap   = '0;
          csn_low    = 0;
          ready_viol = 1'b0;
        end
        if (!c) begin
          csn_low++;
          if (rr[sel]) ready_viol = 1'b1;
          if (!ps && s) begin
            mosi_cap = {mosi_cap[22:0], mosi_w[sel]};
            mon_rises++;
          end
          if (ps && !s) begin
            bit_k++;
            miso = (bit_k < 24) ? pat[23 - bit_k] : 1'b0;
          end
        end else begin
          gap_cnt++;
        end
        if (!pc && c) begin
          gap_cnt = 1;
          low_len = csn_low;
        end
        if (rsp_w[sel]) begin
          check("rsp_one_cycle", {31'd0, pr}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", {24'd0, rdata_w[sel]}, {24'd0, e[7:0]});
            check("mosi_frame", {8'd0, mosi_cap}, {8'd0, e[31:8]});
            check("sclk_rises", mon_rises, 32'd24);
            check("csn_low_cycles", low_len, exp_low);
            check("rsp_latency", cyc - e[63:32], exp_low + 1);
            check("ready_low_in_frame", {31'd0, ready_viol}, 32'd0);
            check("busy_at_rsp", {31'd0, busy_w[sel]}, 32'd1);
          end
        end
        pc = c;
        ps = s;
        pr = rsp_w[sel];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    cyc     = 0;
    sel     = 0;
    opcode  = '0;
    addr    = '0;
    wdata   = '0;
    do_reset(3);
    // Values just after reset is released, before any request.
    for (int s = 0; s < 2; s++) check_reset_vals(s);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset(2);
      // Register read returning 0x80.
      send(s, SPI_OP_RD, 8'h01, 8'h00, 24'h000080, 1'b0);
      wait_idle(s);
      // Back-to-back with req_valid held high.
      send(s, SPI_OP_RD, 8'h01, 8'h00, 24'h000003, 1'b1);
      send(s, SPI_OP_RD, 8'h02, 8'h00, 24'h0000C0, 1'b0);
      wait_idle(s);
      // Boundary miso patterns: all ones, alternating starting with 1.
      send(s, 8'h80, 8'h55, 8'hAA, 24'hFFFFFF, 1'b0);
      send(s, 8'h00, 8'hFF, 8'h01, 24'hAAAAAA, 1'b0);
      wait_idle(s);
      // Request noise during SHIFT must not alter or add a frame.
      send(s, 8'h3C, 8'hC3, 8'h5A, 24'($urandom), 1'b0);
      wait_rises(3);
      opcode = 8'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      rv[s] = 1'b1;
      repeat (4) @(negedge clk);
      rv[s] = 1'b0;
      wait_idle(s);
      // Random frames, sometimes back-to-back.
      for (int i = 0; i < 6; i++) begin
        send(s, 8'($urandom), 8'($urandom), 8'($urandom), 24'($urandom),
             1'($urandom_range(0, 1)));
      end
      rv[s] = 1'b0;
      wait_idle(s);
      // Reset in the middle of a frame.
      send(s, 8'($urandom), 8'($urandom), 8'($urandom), 24'($urandom), 1'b0);
      wait_rises(10);
      rst = 1'b1;
      exp_q.delete();
      miso_q.delete();
      @(negedge clk);
      check_reset_vals(s);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send(s, 8'($urandom), 8'($urandom), 8'($urandom), 24'($urandom), 1'b0);
      wait_idle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
